// File: rtl/mux2_arb.sv
// Two-requester burst arbiter that owns the select of the 2:1 data mux and streams beats downstream.
// Define MUX2_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (req0 wins).
//
// state | meaning
// IDLE  | no grant; arbitrate pending requests
// G0    | requester 0 owns the path, j = 0
// G1    | requester 1 owns the path, j = 1
module mux2_arb #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] i0,
  input  logic         req1,
  input  logic [W-1:0] i1,
  input  logic         o_rdy,
  output logic         gnt0,
  output logic         gnt1,
  output logic         ack0,
  output logic         ack1,
  output logic         j,
  output logic [W-1:0] o,
  output logic         o_vld
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          j_q, j_d;
  logic          arb;
  logic          win1;

  // Arbitration result: win1 set means requester 1 takes the next grant.
`ifdef MUX2_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    win1 = req1 & (~req0 | ~last_q);
  end

  always_comb begin
    last_d = last_q;
    if (state_d == G0) begin
      last_d = 1'b0;
    end else if (state_d == G1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    win1 = req1 & ~req0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
    end
  end

  // A grant is released on its final acked beat or as soon as its requester withdraws;
  // the same edge arbitrates again so a handoff costs no idle cycle.
  always_comb begin
    arb     = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE:    arb = 1'b1;
      G0:      arb = ~req0 | (ack0 & (cnt_q == CNT_LAST));
      G1:      arb = ~req1 | (ack1 & (cnt_q == CNT_LAST));
      default: arb = 1'b1;
    endcase
    if (arb) begin
      if (req0 | req1) begin
        state_d = win1 ? G1 : G0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (arb) begin
      cnt_d = '0;
    end else if (ack0 | ack1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Select follows the owner; it holds its last value while idle.
  always_comb begin
    j_d = j_q;
    if (state_d == G1) begin
      j_d = 1'b1;
    end else if (state_d == G0) begin
      j_d = 1'b0;
    end
  end

  always_comb begin
    gnt0  = (state_q == G0);
    gnt1  = (state_q == G1);
    ack0  = gnt0 & req0 & o_rdy;
    ack1  = gnt1 & req1 & o_rdy;
    o_vld = (gnt0 & req0) | (gnt1 & req1);
    j     = j_q;
    o     = j_q ? i1 : i0;
  end

endmodule

// File: tb/tb_mux2_arb.sv
// Directed bench for mux2_arb: expected beats go into a scoreboard queue, a negedge monitor
// pops one per acknowledged beat. Builds for either arbitration mode (MUX2_ARB_RR_EN).
module tb_mux2_arb;

`ifdef MUX2_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req0, req1, o_rdy;
  logic [7:0] i0, i1;
  logic       gnt0, gnt1, ack0, ack1, j, o_vld;
  logic [7:0] o;

  int total;
  int bad;
  logic [8:0] exp_q[$];

  mux2_arb #(.W(8), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .i0(i0), .req1(req1), .i1(i1), .o_rdy(o_rdy),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .j(j), .o(o), .o_vld(o_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic src, input logic [7:0] d, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({src, d});
  endtask

  // One cycle: drive requests after the rising edge, check grant/select at the falling edge.
  task automatic cyc(input string nm, input logic r0, input logic r1, input logic rdy,
                     input logic eg0, input logic eg1, input logic ej);
    @(posedge clk);
    #1;
    req0  = r0;
    req1  = r1;
    o_rdy = rdy;
    @(negedge clk);
    chk({nm, ".gnt0"}, gnt0, eg0);
    chk({nm, ".gnt1"}, gnt1, eg1);
    chk({nm, ".j"}, j, ej);
  endtask

  // Scoreboard monitor: every consumed beat must match the head of the queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && (ack0 || ack1)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got ack0=%0d ack1=%0d o=%0h want no beat", ack0, ack1, o);
      end else begin
        e = exp_q.pop_front();
        if ({ack0, ack1, o_vld, o} !== {~e[8], e[8], 1'b1, e[7:0]}) begin
          bad++;
          $display("FAIL sb_beat: got ack0=%0d ack1=%0d vld=%0d o=%0h want src=%0d o=%0h",
                   ack0, ack1, o_vld, o, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    logic eg1;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    o_rdy = 1'b1;
    i0    = 8'hA5;
    i1    = 8'h5A;

    // Reset state with both requests pending
    repeat (2) @(negedge clk);
    chk("rst.gnt0", gnt0, 1'b0);
    chk("rst.gnt1", gnt1, 1'b0);
    chk("rst.j", j, 1'b0);
    chk("rst.o_vld", o_vld, 1'b0);
    chk("rst.ack", {ack0, ack1}, 2'b00);
    chk("rst.o", o, i0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel.gnt0", gnt0, 1'b0);

    // Contention: RR alternates 4-beat bursts, fixed priority keeps G0
    push(1'b0, 8'hA5, 4);
    push(RR, RR ? 8'h5A : 8'hA5, 4);
    push(1'b0, 8'hA5, 4);
    for (int c = 1; c <= 12; c++) begin
      eg1 = RR && (c >= 5) && (c <= 8);
      cyc("cont", 1'b1, 1'b1, 1'b1, ~eg1, eg1, eg1);
    end
    cyc("cont_tail", 1'b0, 1'b0, 1'b1, ~RR, RR, RR);
    chk("cont_tail.o_vld", o_vld, 1'b0);
    cyc("cont_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RR);

    // Single requester: two back-to-back bursts, re-granted without a gap
    push(1'b0, 8'hA5, 8);
    cyc("single_req", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, RR);
    for (int c = 0; c < 8; c++) cyc("single", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("single_drop", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("single_drop.o_vld", o_vld, 1'b0);
    cyc("single_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall mid-burst in G1, then handoff to requester 0 after exactly 4 acks
    i1 = 8'h3C;
    push(1'b1, 8'h3C, 4);
    push(1'b0, 8'h77, 1);
    cyc("stall_req", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("stall_b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("stall_b1.cnt", dut.cnt_q, 0);
    for (int c = 0; c < 3; c++) begin
      cyc("stall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("stall.ack1", ack1, 1'b0);
      chk("stall.o_vld", o_vld, 1'b1);
      chk("stall.cnt", dut.cnt_q, 1);
    end
    cyc("stall_b2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("stall_b2.cnt", dut.cnt_q, 1);
    i0 = 8'h77;
    cyc("stall_b3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("stall_b3.cnt", dut.cnt_q, 2);
    cyc("stall_b4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("stall_b4.cnt", dut.cnt_q, 3);
    cyc("stall_hand", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("stall_drop", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall_drop.o_vld", o_vld, 1'b0);
    cyc("stall_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Early release: req0 withdraws after 2 acks, req1 takes over on the next edge
    i0 = 8'h11;
    i1 = 8'h22;
    push(1'b0, 8'h11, 2);
    push(1'b1, 8'h22, 2);
    cyc("early_req", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("early_b1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("early_b2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("early_drop", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("early_drop.ack1", ack1, 1'b0);
    chk("early_drop.o_vld", o_vld, 1'b0);
    cyc("early_g1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("early_g1.o", o, 8'h22);
    cyc("early_g1b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("early_rel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("early_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-burst after one ack in G1; requester keeps its beat and re-arbitrates
    i1 = 8'h66;
    push(1'b1, 8'h66, 1);
    cyc("mrst_req", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("mrst_b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.gnt1", gnt1, 1'b0);
    chk("mrst.j", j, 1'b0);
    chk("mrst.ack1", ack1, 1'b0);
    chk("mrst.o_vld", o_vld, 1'b0);
    chk("mrst.o", o, i0);
    chk("mrst.cnt", dut.cnt_q, 0);
    @(negedge clk);
    chk("mrst_hold.ack1", ack1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel.gnt", {gnt0, gnt1}, 2'b00);
    push(1'b1, 8'h66, 1);
    cyc("mrst_regnt", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mrst_regnt.cnt", dut.cnt_q, 0);
    cyc("mrst_drop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("mrst_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
